// File: rtl/uart_rom_stream_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rom_stream_loader: assembles a big-endian UART byte stream (16-bit word
// count, then 16-bit instructions) and feeds it through the soc rom_loader port.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rom_stream_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  rom_loader_reset_o,
  output logic                  rom_loader_load_o,
  output logic [DATA_WIDTH-1:0] rom_loader_data_o,
  input  logic                  rom_loader_load_received_i,
  input  logic                  rom_loader_ack_i,
  output logic                  done_loading_o,
  output logic                  error_o,
  output logic [1:0]            error_code_o,
  output logic [15:0]           words_loaded_o
);

  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RESET_MAX = RW'(RESET_CYCLES - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_HDR_HI   = 4'd2,
    S_HDR_LO   = 4'd3,
    S_WORD_HI  = 4'd4,
    S_WORD_LO  = 4'd5,
    S_LOAD_REQ = 4'd6,
    S_LOAD_ACK = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_e;

  state_e                state_q, state_d;
  logic                  run_q, run_prev_q;
  logic [15:0]           count_q, count_d;
  logic [7:0]            word_hi_q, word_hi_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           words_q, words_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  ack_pend_q, ack_pend_d;
  logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic                  run_rise;
  logic [15:0]           words_inc;

  assign run_rise  = run_q & ~run_prev_q;
  assign words_inc = words_q + 16'd1;

  assign rx_ready_o = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_WORD_HI) || (state_q == S_WORD_LO);
  assign rom_loader_reset_o = (state_q == S_START);
  // A stray byte during LOAD_REQ aborts the session, so load is withdrawn in that same cycle.
  assign rom_loader_load_o  = (state_q == S_LOAD_REQ) && !rx_valid_i;
  assign rom_loader_data_o  = data_q;
  assign done_loading_o     = done_q;
  assign error_o            = err_q;
  assign error_code_o       = code_q;
  assign words_loaded_o     = words_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_hi_d  = word_hi_q;
    data_d     = data_q;
    words_d    = words_q;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;
    ack_pend_d = ack_pend_q;
    rst_cnt_d  = '0;
    idle_d     = '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (run_rise) begin
          state_d = S_START;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          words_d = 16'd0;
        end
      end
      S_START: begin
        if (rx_valid_i) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = ERR_OVERRUN;
        end else if (rst_cnt_q == RESET_MAX) begin
          state_d = S_HDR_HI;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_HDR_HI: begin
        if (rx_valid_i) begin
          count_d[15:8] = rx_data_i;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (rx_valid_i) begin
          count_d[7:0] = rx_data_i;
          if ({count_q[15:8], rx_data_i} == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WORD_HI;
          end
        end
      end
      S_WORD_HI: begin
        if (rx_valid_i) begin
          word_hi_d = rx_data_i;
          state_d   = S_WORD_LO;
        end
      end
      S_WORD_LO: begin
        if (rx_valid_i) begin
          data_d     = {word_hi_q, rx_data_i};
          ack_pend_d = 1'b0;
          state_d    = S_LOAD_REQ;
        end
      end
      S_LOAD_REQ: begin
        if (rx_valid_i) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = ERR_OVERRUN;
        end else if (rom_loader_load_received_i) begin
          // An ack arriving alongside load_received is remembered for LOAD_ACK.
          ack_pend_d = rom_loader_ack_i;
          state_d    = S_LOAD_ACK;
        end
      end
      S_LOAD_ACK: begin
        if (rx_valid_i) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          code_d  = ERR_OVERRUN;
        end else if (rom_loader_ack_i || ack_pend_q) begin
          ack_pend_d = 1'b0;
          words_d    = words_inc;
          if (words_inc == count_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WORD_HI;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Idle timer only runs while waiting for a byte; any state change leaves it cleared.
    if (rx_ready_o && !rx_valid_i) begin
      if (idle_q == IDLE_MAX) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      run_prev_q <= 1'b0;
      count_q    <= 16'd0;
      word_hi_q  <= 8'd0;
      data_q     <= '0;
      words_q    <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
      ack_pend_q <= 1'b0;
      rst_cnt_q  <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_i;
      run_prev_q <= run_q;
      count_q    <= count_d;
      word_hi_q  <= word_hi_d;
      data_q     <= data_d;
      words_q    <= words_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      ack_pend_q <= ack_pend_d;
      rst_cnt_q  <= rst_cnt_d;
      idle_q     <= idle_d;
    end
  end

endmodule
`default_nettype wire
